// File: rtl/bool_bundle_scheduler.sv
// Packs up to three same-FL Boolean symbols into one stage_1 issue.
// CDF symbols pass through alone; order kept, valid/ready on both sides.
module bool_bundle_scheduler #(
  parameter int RANGE_WIDTH  = 16,
  parameter int SYMBOL_WIDTH = 4,
  parameter int TIMEOUT      = 8,
  parameter int TIMER_WIDTH  = 4
) (
  input  logic                    clk_scheduler,
  input  logic                    reset_scheduler,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_bool,
  input  logic                    in_last,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [SYMBOL_WIDTH:0]   in_nsyms,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RANGE_WIDTH-1:0]  out_fl,
  output logic [RANGE_WIDTH-1:0]  out_fh,
  output logic [SYMBOL_WIDTH:0]   out_nsyms,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_1,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_2,
  output logic [SYMBOL_WIDTH-1:0] out_symbol_3,
  output logic                    out_bool_flag_1,
  output logic                    out_bool_flag_2,
  output logic                    out_bool_flag_3,
  output logic [1:0]              out_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  localparam logic [TIMER_WIDTH-1:0] TO_LIM = TIMER_WIDTH'(TIMEOUT);
  localparam logic [TIMER_WIDTH-1:0] T_MAX  = '1;
  localparam logic [SYMBOL_WIDTH:0]  BOOL_NS = (SYMBOL_WIDTH+1)'(2);

  state_e                  state_q, state_d;
  logic [RANGE_WIDTH-1:0]  acc_fl_q, acc_fl_d, acc_fh_q, acc_fh_d;
  logic [SYMBOL_WIDTH-1:0] acc_s1_q, acc_s1_d, acc_s2_q, acc_s2_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic                    ov_q, ov_d;
  logic [RANGE_WIDTH-1:0]  ofl_q, ofl_d, ofh_q, ofh_d;
  logic [SYMBOL_WIDTH:0]   ons_q, ons_d;
  logic [SYMBOL_WIDTH-1:0] os1_q, os1_d, os2_q, os2_d, os3_q, os3_d;
  logic                    of1_q, of1_d, of2_q, of2_d, of3_q, of3_d;
  logic [1:0]              ocnt_q, ocnt_d;

  logic out_free, compat, flush;
  logic r_flush, r_app, r_close, r_cdf;

  assign out_free = !ov_q || out_ready;
  assign compat   = in_bool && (state_q == EMPTY || in_fl == acc_fl_q);
  assign r_flush  = !compat && state_q != EMPTY;
  assign r_app    = compat && state_q != TWO && !in_last;
  assign r_close  = compat && (state_q == TWO || in_last);
  assign r_cdf    = !in_bool && state_q == EMPTY;

  always_comb begin
    state_d  = state_q;
    acc_fl_d = acc_fl_q;
    acc_fh_d = acc_fh_q;
    acc_s1_d = acc_s1_q;
    acc_s2_d = acc_s2_q;
    timer_d  = timer_q;
    ov_d     = ov_q;
    ofl_d    = ofl_q;
    ofh_d    = ofh_q;
    ons_d    = ons_q;
    os1_d    = os1_q;
    os2_d    = os2_q;
    os3_d    = os3_q;
    of1_d    = of1_q;
    of2_d    = of2_q;
    of3_d    = of3_q;
    ocnt_d   = ocnt_q;
    in_ready = 1'b0;
    flush    = 1'b0;
    if (ov_q && out_ready) ov_d = 1'b0;
    if (in_valid) begin
      unique case (1'b1)
        r_flush: flush = out_free;
        r_app: begin
          in_ready = 1'b1;
          timer_d  = '0;
          if (state_q == EMPTY) begin
            acc_fl_d = in_fl;
            acc_fh_d = in_fh;
            acc_s1_d = in_symbol;
            state_d  = ONE;
          end else begin
            acc_s2_d = in_symbol;
            state_d  = TWO;
          end
        end
        r_close: begin
          in_ready = out_free;
          if (out_free) begin
            ov_d    = 1'b1;
            timer_d = '0;
            state_d = EMPTY;
            ofl_d   = (state_q == EMPTY) ? in_fl : acc_fl_q;
            ofh_d   = (state_q == EMPTY) ? in_fh : acc_fh_q;
            ons_d   = BOOL_NS;
            os1_d   = in_symbol;
            os2_d   = '0;
            os3_d   = '0;
            of1_d   = 1'b0;
            of2_d   = 1'b1;
            of3_d   = 1'b1;
            ocnt_d  = 2'd1;
            if (state_q == ONE) begin
              os1_d  = acc_s1_q;
              os2_d  = in_symbol;
              of2_d  = 1'b0;
              ocnt_d = 2'd2;
            end
            if (state_q == TWO) begin
              os1_d  = acc_s1_q;
              os2_d  = acc_s2_q;
              os3_d  = in_symbol;
              of2_d  = 1'b0;
              of3_d  = 1'b0;
              ocnt_d = 2'd3;
            end
          end
        end
        r_cdf: begin
          in_ready = out_free;
          if (out_free) begin
            ov_d   = 1'b1;
            ofl_d  = in_fl;
            ofh_d  = in_fh;
            ons_d  = in_nsyms;
            os1_d  = in_symbol;
            os2_d  = '0;
            os3_d  = '0;
            of1_d  = 1'b1;
            of2_d  = 1'b1;
            of3_d  = 1'b1;
            ocnt_d = 2'd1;
          end
        end
        default: ;
      endcase
    end else if (state_q != EMPTY) begin
      if (timer_q >= TO_LIM && out_free) flush = 1'b1;
      else if (timer_q != T_MAX) timer_d = timer_q + 1'b1;
    end
    // Partial bundle leaves with only the held symbols enabled
    if (flush) begin
      ov_d    = 1'b1;
      state_d = EMPTY;
      timer_d = '0;
      ofl_d   = acc_fl_q;
      ofh_d   = acc_fh_q;
      ons_d   = BOOL_NS;
      os1_d   = acc_s1_q;
      os2_d   = (state_q == TWO) ? acc_s2_q : '0;
      os3_d   = '0;
      of1_d   = 1'b0;
      of2_d   = (state_q != TWO);
      of3_d   = 1'b1;
      ocnt_d  = (state_q == TWO) ? 2'd2 : 2'd1;
    end
  end

  always_ff @(posedge clk_scheduler or posedge reset_scheduler) begin
    if (reset_scheduler) begin
      state_q  <= EMPTY;
      acc_fl_q <= '0;
      acc_fh_q <= '0;
      acc_s1_q <= '0;
      acc_s2_q <= '0;
      timer_q  <= '0;
      ov_q     <= 1'b0;
      ofl_q    <= '0;
      ofh_q    <= '0;
      ons_q    <= '0;
      os1_q    <= '0;
      os2_q    <= '0;
      os3_q    <= '0;
      of1_q    <= 1'b1;
      of2_q    <= 1'b1;
      of3_q    <= 1'b1;
      ocnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_fl_q <= acc_fl_d;
      acc_fh_q <= acc_fh_d;
      acc_s1_q <= acc_s1_d;
      acc_s2_q <= acc_s2_d;
      timer_q  <= timer_d;
      ov_q     <= ov_d;
      ofl_q    <= ofl_d;
      ofh_q    <= ofh_d;
      ons_q    <= ons_d;
      os1_q    <= os1_d;
      os2_q    <= os2_d;
      os3_q    <= os3_d;
      of1_q    <= of1_d;
      of2_q    <= of2_d;
      of3_q    <= of3_d;
      ocnt_q   <= ocnt_d;
    end
  end

  assign out_valid       = ov_q;
  assign out_fl          = ofl_q;
  assign out_fh          = ofh_q;
  assign out_nsyms       = ons_q;
  assign out_symbol_1    = os1_q;
  assign out_symbol_2    = os2_q;
  assign out_symbol_3    = os3_q;
  assign out_bool_flag_1 = of1_q;
  assign out_bool_flag_2 = of2_q;
  assign out_bool_flag_3 = of3_q;
  assign out_count       = ocnt_q;

endmodule

// File: tb/tb_bool_bundle_scheduler.sv
// Bench for bool_bundle_scheduler: vector table plus corner sequences,
// every delivered bundle checked against a scoreboard queue.
module tb_bool_bundle_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_bool, in_last;
  logic [15:0] in_fl, in_fh;
  logic [3:0]  in_symbol;
  logic [4:0]  in_nsyms;
  logic        out_valid, out_ready;
  logic [15:0] out_fl, out_fh;
  logic [4:0]  out_nsyms;
  logic [3:0]  out_symbol_1, out_symbol_2, out_symbol_3;
  logic        out_bool_flag_1, out_bool_flag_2, out_bool_flag_3;
  logic [1:0]  out_count;

  always #5 clk = ~clk;

  bool_bundle_scheduler #(
    .RANGE_WIDTH(16), .SYMBOL_WIDTH(4), .TIMEOUT(8), .TIMER_WIDTH(4)
  ) dut (
    .clk_scheduler(clk), .reset_scheduler(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bool(in_bool), .in_last(in_last),
    .in_fl(in_fl), .in_fh(in_fh),
    .in_symbol(in_symbol), .in_nsyms(in_nsyms),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fl(out_fl), .out_fh(out_fh), .out_nsyms(out_nsyms),
    .out_symbol_1(out_symbol_1), .out_symbol_2(out_symbol_2),
    .out_symbol_3(out_symbol_3),
    .out_bool_flag_1(out_bool_flag_1),
    .out_bool_flag_2(out_bool_flag_2),
    .out_bool_flag_3(out_bool_flag_3),
    .out_count(out_count)
  );

  typedef struct packed {
    logic [15:0] fl, fh;
    logic [4:0]  ns;
    logic [3:0]  s1, s2, s3;
    logic        f1, f2, f3;
    logic [1:0]  cnt;
  } bund_t;

  typedef struct packed {
    logic        b, last;
    logic [15:0] fl, fh;
    logic [3:0]  sym;
    logic [4:0]  ns;
  } elem_t;

  typedef struct {
    elem_t e;
    int    stall;
    int    ne;
    bund_t x0;
    bund_t x1;
  } vec_t;

  bund_t sb[$];
  int    errors = 0;
  int    checks = 0;

  function automatic bund_t bb(input logic [15:0] fl, fh,
                               input logic [3:0] s1, s2, s3,
                               input logic f1, f2, f3,
                               input logic [1:0] cnt);
    bund_t r;
    r = '{fl: fl, fh: fh, ns: 5'd2, s1: s1, s2: s2, s3: s3,
          f1: f1, f2: f2, f3: f3, cnt: cnt};
    return r;
  endfunction

  function automatic bund_t cb(input logic [15:0] fl, fh,
                               input logic [4:0] ns,
                               input logic [3:0] s1);
    bund_t r;
    r = '{fl: fl, fh: fh, ns: ns, s1: s1, s2: 4'd0, s3: 4'd0,
          f1: 1'b1, f2: 1'b1, f3: 1'b1, cnt: 2'd1};
    return r;
  endfunction

  function automatic elem_t eb(input logic [15:0] fl, fh,
                               input logic [3:0] sym, input logic last);
    elem_t r;
    r = '{b: 1'b1, last: last, fl: fl, fh: fh, sym: sym, ns: 5'd2};
    return r;
  endfunction

  function automatic elem_t ec(input logic [15:0] fl, fh,
                               input logic [3:0] sym,
                               input logic [4:0] ns, input logic last);
    elem_t r;
    r = '{b: 1'b0, last: last, fl: fl, fh: fh, sym: sym, ns: ns};
    return r;
  endfunction

  function automatic vec_t v(input elem_t e, input int st, input int ne,
                             input bund_t a, input bund_t b);
    vec_t r;
    r.e = e;
    r.stall = st;
    r.ne = ne;
    r.x0 = a;
    r.x1 = b;
    return r;
  endfunction

  function automatic bund_t dut_b();
    bund_t r;
    r = '{fl: out_fl, fh: out_fh, ns: out_nsyms,
          s1: out_symbol_1, s2: out_symbol_2, s3: out_symbol_3,
          f1: out_bool_flag_1, f2: out_bool_flag_2,
          f3: out_bool_flag_3, cnt: out_count};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  bund_t held;
  bit    held_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) chk("hold", {out_valid, dut_b()}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected bundle got=%h exp=none", dut_b());
        end else begin
          chk("bundle", dut_b(), sb.pop_front());
        end
      end
      held_v = out_valid && !out_ready;
      held = dut_b();
    end
  end

  task automatic send(input elem_t e, output int stall);
    bit acc;
    bit done;
    done = 1'b0;
    stall = 0;
    in_valid = 1'b1;
    in_bool = e.b;
    in_last = e.last;
    in_fl = e.fl;
    in_fh = e.fh;
    in_symbol = e.sym;
    in_nsyms = e.ns;
    while (!done) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        done = 1'b1;
      end else begin
        stall++;
        if (stall > 200) begin
          checks++;
          errors++;
          $display("FAIL send_timeout got=no_accept exp=accept");
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[14];
    int   st;
    int   first;
    bund_t z;
    z = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bool = 1'b0;
    in_last = 1'b0;
    in_fl = '0;
    in_fh = '0;
    in_symbol = '0;
    in_nsyms = '0;
    out_ready = 1'b1;

    tv[0]  = v(eb(16'h4000, 16'h1000, 4'd1, 1'b0), 0, 0, z, z);
    tv[1]  = v(eb(16'h4000, 16'h1100, 4'd0, 1'b0), 0, 0, z, z);
    tv[2]  = v(eb(16'h4000, 16'h1200, 4'd1, 1'b0), 0, 1,
               bb(16'h4000, 16'h1000, 1, 0, 1, 0, 0, 0, 3), z);
    tv[3]  = v(eb(16'h6000, 16'h0300, 4'd1, 1'b0), 0, 0, z, z);
    tv[4]  = v(eb(16'h6000, 16'h0400, 4'd0, 1'b0), 0, 0, z, z);
    tv[5]  = v(ec(16'h8000, 16'h2000, 4'd5, 5'd8, 1'b0), 1, 2,
               bb(16'h6000, 16'h0300, 1, 0, 0, 0, 0, 1, 2),
               cb(16'h8000, 16'h2000, 5'd8, 4'd5));
    tv[6]  = v(eb(16'h4000, 16'h0500, 4'd1, 1'b0), 0, 0, z, z);
    tv[7]  = v(eb(16'h5000, 16'h0600, 4'd0, 1'b0), 1, 1,
               bb(16'h4000, 16'h0500, 1, 0, 0, 0, 1, 1, 1), z);
    tv[8]  = v(eb(16'h5000, 16'h0700, 4'd1, 1'b1), 0, 1,
               bb(16'h5000, 16'h0600, 0, 1, 0, 0, 0, 1, 2), z);
    tv[9]  = v(eb(16'h7000, 16'h0800, 4'd1, 1'b1), 0, 1,
               bb(16'h7000, 16'h0800, 1, 0, 0, 0, 1, 1, 1), z);
    tv[10] = v(ec(16'h1234, 16'h0100, 4'd3, 5'd16, 1'b1), 0, 1,
               cb(16'h1234, 16'h0100, 5'd16, 4'd3), z);
    tv[11] = v(ec(16'h2000, 16'h0200, 4'd15, 5'd5, 1'b0), 0, 1,
               cb(16'h2000, 16'h0200, 5'd5, 4'd15), z);
    tv[12] = v(eb(16'h2000, 16'h0900, 4'd1, 1'b0), 0, 0, z, z);
    tv[13] = v(ec(16'h3000, 16'h0300, 4'd2, 5'd4, 1'b0), 1, 2,
               bb(16'h2000, 16'h0900, 1, 0, 0, 0, 1, 1, 1),
               cb(16'h3000, 16'h0300, 5'd4, 4'd2));

    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_flags",
        64'({out_bool_flag_1, out_bool_flag_2, out_bool_flag_3}),
        64'd7);
    chk("rst_data",
        64'({out_fl, out_fh, out_nsyms, out_symbol_1, out_symbol_2,
             out_symbol_3, out_count}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (tv[i].ne > 0) sb.push_back(tv[i].x0);
      if (tv[i].ne > 1) sb.push_back(tv[i].x1);
      send(tv[i].e, st);
      chk($sformatf("stall[%0d]", i), 64'(st), 64'(tv[i].stall));
    end
    drain();

    // full bundle appears exactly one cycle after the third accept
    sb.push_back(bb(16'hC000, 16'h0C00, 0, 1, 1, 0, 0, 0, 3));
    send(eb(16'hC000, 16'h0C00, 4'd0, 1'b0), st);
    send(eb(16'hC000, 16'h0C10, 4'd1, 1'b0), st);
    chk("lat_before", 64'(out_valid), 64'd0);
    send(eb(16'hC000, 16'h0C20, 4'd1, 1'b0), st);
    chk("lat_after", 64'(out_valid), 64'd1);
    drain();

    // idle flush of a lone Boolean
    sb.push_back(bb(16'hB000, 16'h0B00, 1, 0, 0, 0, 1, 1, 1));
    send(eb(16'hB000, 16'h0B00, 4'd1, 1'b0), st);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (first == 0 && out_valid) first = k;
    end
    chk("timeout_cycle", 64'(first), 64'd10);
    @(posedge clk);
    #1;
    drain();

    // CDF stream under output backpressure
    fork
      begin
        int s2;
        for (int i = 0; i < 4; i++) begin
          sb.push_back(cb(16'(256 * (i + 1)), 16'(i), 5'(i + 2), 4'(i + 1)));
          send(ec(16'(256 * (i + 1)), 16'(i), 4'(i + 1), 5'(i + 2), 1'b0), s2);
        end
      end
      begin
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // asynchronous reset with a full accumulator and a held output
    out_ready = 1'b0;
    send(ec(16'h0400, 16'h0040, 4'd9, 5'd12, 1'b0), st);
    send(eb(16'h9000, 16'h0900, 4'd1, 1'b0), st);
    send(eb(16'h9000, 16'h0910, 4'd0, 1'b0), st);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_flags",
        64'({out_bool_flag_1, out_bool_flag_2, out_bool_flag_3}),
        64'd7);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    sb.push_back(bb(16'hA000, 16'h0A00, 1, 0, 0, 0, 1, 1, 1));
    send(eb(16'hA000, 16'h0A00, 4'd1, 1'b1), st);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
